fetch_stall_ctrl: RTL and testbench

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

---
 rtl/fetch_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// Fetch/stall controller: load-use interlock, I-mem wait and redirect squash, fetch watchdog.
// Optional FETCH_STALL_PERFCNT_EN adds stall_cycles/flush_count performance counters.
module fetch_stall_ctrl #(
    parameter int WDOG_W = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        imem_ack,
    output logic        imem_req,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [1:0]  pcsrc,
    output logic        wpcir,
    output logic        wir,
    output logic        if_nop,
    output logic        id_bubble,
    output logic [1:0]  state,
    output logic        fetch_err,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_MISS  = 2'd2;
    localparam logic [1:0] S_REDIR = 2'd3;

    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              fetch_err_q, fetch_err_d;
    logic              load_use;
    logic              redirect;

    assign load_use = ewreg & em2reg & (ern != 5'd0) &
                      ((use_rs & (rs == ern)) | (use_rt & (rt == ern)));
    assign redirect = (pcsrc != 2'b00);

    // imem_req depends on state only, so there is no ack-to-req combinational path.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        wpcir    = 1'b0;
        wir      = 1'b0;
        if_nop   = 1'b0;
        if (state_q == S_BOOT) begin
            state_d = S_RUN;
        end else begin
            imem_req = 1'b1;
            if (load_use) begin
                state_d = imem_ack ? S_RUN : S_MISS;
            end else if (imem_ack) begin
                wpcir   = 1'b1;
                wir     = 1'b1;
                if_nop  = redirect;
                state_d = S_RUN;
            end else begin
                state_d = redirect ? S_REDIR : S_MISS;
            end
        end
        id_bubble = ~wir;
    end

    always_comb begin
        wdog_d      = wdog_q;
        fetch_err_d = fetch_err_q;
        if (imem_ack || (state_q == S_RUN && state_d == S_RUN)) begin
            wdog_d = '0;
        end else if ((state_q == S_MISS || state_q == S_REDIR) && wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (wdog_d == WDOG_MAX) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_BOOT;
            wdog_q      <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign state     = state_q;
    assign fetch_err = fetch_err_q;

`ifdef FETCH_STALL_PERFCNT_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q + ((state_q != S_BOOT && !wir) ? 32'd1 : 32'd0);
        flush_d = flush_q + {15'd0, if_nop};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench for fetch_stall_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_fetch_stall_ctrl;

    localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, MISS = 2'd2, REDIR = 2'd3;

    typedef struct packed {
        logic [1:0]  st;
        logic        req;
        logic        wpc;
        logic        wir;
        logic        nop;
        logic        bub;
        logic        err;
        logic [31:0] stall;
        logic [15:0] flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        imem_ack;
    logic        imem_req;
    logic [4:0]  rs, rt, ern;
    logic        use_rs, use_rt, ewreg, em2reg;
    logic [1:0]  pcsrc;
    logic        wpcir, wir, if_nop, id_bubble;
    logic [1:0]  state;
    logic        fetch_err;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    exp_t exp_q[$];
    int   vec_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vec_no = 0;
    logic [31:0] acc_stall = '0;
    logic [15:0] acc_flush = '0;

    fetch_stall_ctrl #(.WDOG_W(8)) dut (
        .clk(clk), .clrn(clrn), .imem_ack(imem_ack), .imem_req(imem_req),
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .pcsrc(pcsrc),
        .wpcir(wpcir), .wir(wir), .if_nop(if_nop), .id_bubble(id_bubble),
        .state(state), .fetch_err(fetch_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        exp_t e, a;
        int   v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                v = vec_q.pop_front();
                a = '{st: state, req: imem_req, wpc: wpcir, wir: wir, nop: if_nop,
                      bub: id_bubble, err: fetch_err, stall: stall_cycles, flush: flush_count};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL vec%0d: actual st=%0d req=%b wpc=%b wir=%b nop=%b bub=%b err=%b stall=%0d flush=%0d; expected st=%0d req=%b wpc=%b wir=%b nop=%b bub=%b err=%b stall=%0d flush=%0d",
                             v, a.st, a.req, a.wpc, a.wir, a.nop, a.bub, a.err, a.stall, a.flush,
                             e.st, e.req, e.wpc, e.wir, e.nop, e.bub, e.err, e.stall, e.flush);
                end
            end
        end
    end

    // Called just after a rising edge; drives one cycle and queues its expected outputs.
    task automatic step(input logic ack, input logic [1:0] pc, input logic [1:0] st,
                        input logic req, input logic wpc, input logic w, input logic nop,
                        input logic err);
        exp_t e;
        imem_ack = ack;
        pcsrc    = pc;
        if (!clrn) begin
            acc_stall = '0;
            acc_flush = '0;
        end
        e.st = st; e.req = req; e.wpc = wpc; e.wir = w; e.nop = nop; e.bub = ~w; e.err = err;
`ifdef FETCH_STALL_PERFCNT_EN
        e.stall = acc_stall;
        e.flush = acc_flush;
        if (st != BOOT && !w) acc_stall = acc_stall + 32'd1;
        if (nop) acc_flush = acc_flush + 16'd1;
`else
        e.stall = '0;
        e.flush = '0;
`endif
        exp_q.push_back(e);
        vec_q.push_back(vec_no);
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_hz();
        rs = 5'd0; rt = 5'd0; ern = 5'd0;
        use_rs = 1'b0; use_rt = 1'b0; ewreg = 1'b0; em2reg = 1'b0;
    endtask

    initial begin : driver
        clrn = 1'b0; imem_ack = 1'b1; pcsrc = 2'b00;
        clr_hz();
        @(posedge clk);
        #1;
        // Held in reset: BOOT outputs regardless of inputs
        step(1, 2'b00, BOOT, 0, 0, 0, 0, 0);
        step(0, 2'b01, BOOT, 0, 0, 0, 0, 0);
        clrn = 1'b1;
        step(1, 2'b00, BOOT, 0, 0, 0, 0, 0);
        repeat (3) step(1, 2'b00, RUN, 1, 1, 1, 0, 0);

        // Load-use on rs with ack: stall one cycle, then ern=0 releases
        ewreg = 1; em2reg = 1; ern = 5'd5; rs = 5'd5; use_rs = 1;
        step(1, 2'b00, RUN, 1, 0, 0, 0, 0);
        ern = 5'd0;
        step(1, 2'b00, RUN, 1, 1, 1, 0, 0);
        // Matching rt but not used / not a load: no interlock
        ern = 5'd7; rt = 5'd7; use_rs = 0; use_rt = 0;
        step(1, 2'b00, RUN, 1, 1, 1, 0, 0);
        em2reg = 0; use_rt = 1;
        step(1, 2'b00, RUN, 1, 1, 1, 0, 0);
        // Load-use on rt with no ack and a redirect: pcsrc ignored, goes MISS
        em2reg = 1;
        step(0, 2'b01, RUN, 1, 0, 0, 0, 0);
        clr_hz();
        step(1, 2'b00, MISS, 1, 1, 1, 0, 0);

        // Redirect while waiting: REDIR, then squash on ack
        step(0, 2'b01, RUN,   1, 0, 0, 0, 0);
        repeat (3) step(0, 2'b01, REDIR, 1, 0, 0, 0, 0);
        step(1, 2'b01, REDIR, 1, 1, 1, 1, 0);
        step(1, 2'b00, RUN,   1, 1, 1, 0, 0);
        step(1, 2'b10, RUN,   1, 1, 1, 1, 0);
        step(1, 2'b11, RUN,   1, 1, 1, 1, 0);
        step(1, 2'b00, RUN,   1, 1, 1, 0, 0);

        // MISS <-> REDIR transitions
        step(0, 2'b00, RUN,   1, 0, 0, 0, 0);
        step(0, 2'b01, MISS,  1, 0, 0, 0, 0);
        step(0, 2'b00, REDIR, 1, 0, 0, 0, 0);
        step(1, 2'b00, MISS,  1, 1, 1, 0, 0);
        // Load-use in MISS with ack returns to RUN
        step(0, 2'b00, RUN,   1, 0, 0, 0, 0);
        ewreg = 1; em2reg = 1; ern = 5'd3; rs = 5'd3; use_rs = 1;
        step(1, 2'b00, MISS,  1, 0, 0, 0, 0);
        clr_hz();
        step(1, 2'b00, RUN,   1, 1, 1, 0, 0);

        // Watchdog: 255 MISS cycles saturate the counter and set the sticky error
        step(0, 2'b00, RUN, 1, 0, 0, 0, 0);
        for (int i = 1; i < 300; i++) step(0, 2'b00, MISS, 1, 0, 0, 0, (i >= 256));
        step(1, 2'b00, MISS, 1, 1, 1, 0, 1);
        step(1, 2'b00, RUN,  1, 1, 1, 0, 1);
        step(1, 2'b01, RUN,  1, 1, 1, 1, 1);

        // Reset mid-MISS abandons the fetch and clears everything
        step(0, 2'b00, RUN,  1, 0, 0, 0, 1);
        step(0, 2'b00, MISS, 1, 0, 0, 0, 1);
        clrn = 1'b0;
        step(0, 2'b00, BOOT, 0, 0, 0, 0, 0);
        step(1, 2'b00, BOOT, 0, 0, 0, 0, 0);
        clrn = 1'b1;
        step(1, 2'b00, BOOT, 0, 0, 0, 0, 0);
        step(1, 2'b00, RUN,  1, 1, 1, 0, 0);
        step(1, 2'b00, RUN,  1, 1, 1, 0, 0);

        // Drain: the monitor must have consumed every queued expectation
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
